// File: rtl/uart_alu_ctrl.sv
// rtl/uart_alu_ctrl.sv - frame sequencer: 3-byte request (op, A, B) in, 2-byte ALU result out
module uart_alu_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       busy,
    output logic       err_opcode,
    output logic       err_timeout,
    output logic [7:0] pkt_count
);
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        EXEC    = 3'd3,
        SEND_HI = 3'd4,
        SEND_LO = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [7:0]             r_op;
    logic [7:0]             r_a;
    logic [7:0]             r_b;
    logic [15:0]            r_result;
    logic [15:0]            w_alu;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic [7:0]             r_pkt;
    logic                   w_in_get;
    logic                   w_s_hs;
    logic                   w_m_hs;
    logic                   w_timeout;

    assign s_axis_tready = (r_state == IDLE) || (r_state == GET_A) || (r_state == GET_B);
    assign m_axis_tvalid = (r_state == SEND_HI) || (r_state == SEND_LO);
    assign m_axis_tdata  = (r_state == SEND_HI) ? r_result[15:8] :
                           (r_state == SEND_LO) ? r_result[7:0]  : 8'h00;
    assign busy          = (r_state != IDLE);
    assign pkt_count     = r_pkt;

    assign w_in_get  = (r_state == GET_A) || (r_state == GET_B);
    assign w_s_hs    = s_axis_tvalid && s_axis_tready;
    assign w_m_hs    = m_axis_tvalid && m_axis_tready;
    // An accept in the expiry cycle takes priority over the timeout.
    assign w_timeout = w_in_get && !w_s_hs && (r_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));

    assign err_timeout = w_timeout;
    assign err_opcode  = (r_state == EXEC) && (r_op > 8'h05);

    always_comb begin
        w_alu = 16'hFFFF;
        case (r_op)
            8'h00:   w_alu = {7'b0, {1'b0, r_a} + {1'b0, r_b}};
            8'h01:   w_alu = {7'b0, (r_a < r_b), r_a - r_b};
            8'h02:   w_alu = {8'h00, r_a & r_b};
            8'h03:   w_alu = {8'h00, r_a | r_b};
            8'h04:   w_alu = {8'h00, r_a ^ r_b};
            8'h05:   w_alu = {8'h00, r_a} * {8'h00, r_b};
            default: w_alu = 16'hFFFF;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_s_hs) w_next = GET_A;
            GET_A:   if (w_s_hs) w_next = GET_B; else if (w_timeout) w_next = IDLE;
            GET_B:   if (w_s_hs) w_next = EXEC;  else if (w_timeout) w_next = IDLE;
            EXEC:    w_next = SEND_HI;
            SEND_HI: if (w_m_hs) w_next = SEND_LO;
            SEND_LO: if (w_m_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= 8'h00;
            r_a      <= 8'h00;
            r_b      <= 8'h00;
            r_result <= 16'h0000;
            r_cnt    <= '0;
            r_pkt    <= 8'h00;
        end else begin
            r_state <= w_next;
            if (w_s_hs && r_state == IDLE)  r_op <= s_axis_tdata;
            if (w_s_hs && r_state == GET_A) r_a  <= s_axis_tdata;
            if (w_s_hs && r_state == GET_B) r_b  <= s_axis_tdata;
            if (r_state == EXEC)            r_result <= w_alu;
            if (w_m_hs && r_state == SEND_LO) r_pkt <= r_pkt + 8'h01;
            if (w_in_get && !w_s_hs && !w_timeout)
                r_cnt <= r_cnt + TIMEOUT_W'(1);
            else
                r_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// tb/tb_uart_alu_ctrl.sv - directed and randomized frame checks against an arithmetic reference model
module tb_uart_alu_ctrl;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       busy;
    logic       err_opcode;
    logic       err_timeout;
    logic [7:0] pkt_count;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_pkt  = 0;

    uart_alu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .err_opcode(err_opcode), .err_timeout(err_timeout), .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [15:0] model(input int op, input int a, input int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = ((a - b + 256) % 256) + ((a < b) ? 256 : 0);
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a * b;
            default: r = 65535;
        endcase
        return r[15:0];
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        t = 0;
        while (!s_axis_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_wait", 16'd1, 16'd0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic recv_byte(input logic [7:0] exp, input int stall, input string tag);
        for (int k = 0; k < stall; k++) begin
            check({tag, "_stall_valid"}, 16'(m_axis_tvalid), 16'd1);
            check({tag, "_stall_data"}, 16'(m_axis_tdata), 16'(exp));
            check({tag, "_stall_rdy"}, 16'(s_axis_tready), 16'd0);
            check({tag, "_stall_to"}, 16'(err_timeout), 16'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, 16'(m_axis_tvalid), 16'd1);
        check({tag, "_data"}, 16'(m_axis_tdata), 16'(exp));
        m_axis_tready = 1'b1;
        @(negedge clk);
        m_axis_tready = 1'b0;
    endtask

    task automatic do_frame(input int op, input int a, input int b, input int stall_hi,
                            input int stall_lo, input int gap, input string tag);
        logic [15:0] r;
        r = model(op, a, b);
        send_byte(8'(op), gap);
        send_byte(8'(a), gap);
        send_byte(8'(b), gap);
        check({tag, "_exec_valid"}, 16'(m_axis_tvalid), 16'd0);
        check({tag, "_err_opcode"}, 16'(err_opcode), (op > 5) ? 16'd1 : 16'd0);
        check({tag, "_exec_busy"}, 16'(busy), 16'd1);
        @(negedge clk);
        check({tag, "_err_op_clr"}, 16'(err_opcode), 16'd0);
        recv_byte(r[15:8], stall_hi, {tag, "_hi"});
        recv_byte(r[7:0], stall_lo, {tag, "_lo"});
        exp_pkt = (exp_pkt + 1) % 256;
        check({tag, "_busy_after"}, 16'(busy), 16'd0);
        check({tag, "_pkt"}, 16'(pkt_count), 16'(exp_pkt));
        check({tag, "_rdy_after"}, 16'(s_axis_tready), 16'd1);
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = 8'h00;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 16'(m_axis_tvalid), 16'd0);
        check("rst_data", 16'(m_axis_tdata), 16'd0);
        check("rst_rdy", 16'(s_axis_tready), 16'd1);
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_pkt", 16'(pkt_count), 16'd0);
        check("rst_errs", {14'd0, err_opcode, err_timeout}, 16'd0);
        rst = 1'b0;
        @(negedge clk);

        do_frame(8'h00, 8'hC8, 8'h64, 0, 0, 0, "add");
        do_frame(8'h01, 8'h05, 8'h07, 0, 0, 0, "sub");
        do_frame(8'h05, 8'hFF, 8'hFF, 1, 2, 0, "mul");
        do_frame(8'h09, 8'h12, 8'h34, 0, 0, 0, "badop");
        do_frame(8'h03, 8'h0F, 8'hA0, 50, 3, 0, "bp");

        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        for (int k = 0; k < TO; k++) begin
            check("to_early", 16'(err_timeout), 16'd0);
            check("to_busy", 16'(busy), 16'd1);
            @(negedge clk);
        end
        check("to_pulse", 16'(err_timeout), 16'd1);
        check("to_noout", 16'(m_axis_tvalid), 16'd0);
        @(negedge clk);
        check("to_idle", 16'(busy), 16'd0);
        check("to_pulse_end", 16'(err_timeout), 16'd0);
        do_frame(8'h02, 8'hF0, 8'h3C, 0, 0, 0, "after_to");

        send_byte(8'h00, 0);
        send_byte(8'h11, TO - 1);
        send_byte(8'h22, TO);
        check("late_accept_busy", 16'(busy), 16'd1);
        check("late_accept_to", 16'(err_timeout), 16'd0);
        @(negedge clk);
        recv_byte(8'h00, 0, "late_hi");
        recv_byte(8'h33, 0, "late_lo");
        exp_pkt = (exp_pkt + 1) % 256;
        check("late_pkt", 16'(pkt_count), 16'(exp_pkt));

        send_byte(8'h00, 0);
        send_byte(8'hC8, 0);
        send_byte(8'h64, 0);
        @(negedge clk);
        check("rm_hi_valid", 16'(m_axis_tvalid), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pkt = 0;
        check("rm_valid", 16'(m_axis_tvalid), 16'd0);
        check("rm_busy", 16'(busy), 16'd0);
        check("rm_pkt", 16'(pkt_count), 16'd0);
        check("rm_rdy", 16'(s_axis_tready), 16'd1);
        do_frame(8'h04, 8'hAA, 8'h55, 0, 0, 0, "after_rst");

        for (int i = 0; i < 40; i++)
            do_frame($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
